pmem_burst_arbiter: RTL and testbench

- Shares the single 64-bit burst physical-memory port between the instruction-side requester (prefetch unit) and the data-side requester (eviction buffer).
- Converts each 256-bit cache-line request into a fixed 4-beat burst.
- Arbitrates round-robin when both requesters are pending.
- Returns a whole line with a one-cycle response pulse.

---
 rtl/pmem_burst_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_pmem_burst_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmem_burst_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pmem_burst_arbiter
// Purpose  : Shares one 64-bit burst physical-memory port between the
//            instruction-side requester (prefetch) and the data-side
//            requester (eviction buffer). Each 256-bit line request becomes
//            a fixed 4-beat burst; simultaneous requests alternate
//            round-robin; the finished line is returned with a one-cycle
//            response pulse.
// Ports    : clk, rst (synchronous, active-low)
//            inst_pmem_*  : instruction line read request / line response
//            data_pmem_*  : data line read or write request / line response
//            pmem_*       : 64-bit burst memory port (base address is
//                           line aligned, beats advance on pmem_resp)
// Options  : PMEM_ARB_STATS_EN adds inst_grant_cnt, data_grant_cnt and
//            wait_cycles statistics outputs.
// Revision : 1.0 - initial release
// ============================================================================
module pmem_burst_arbiter #(
    parameter int LINE_W = 256,
    parameter int BEAT_W = 64,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] inst_pmem_address,
    input  logic              inst_pmem_read,
    output logic [LINE_W-1:0] inst_pmem_rdata,
    output logic              inst_pmem_resp,
    input  logic [ADDR_W-1:0] data_pmem_address,
    input  logic              data_pmem_read,
    input  logic              data_pmem_write,
    input  logic [LINE_W-1:0] data_pmem_wdata,
    output logic [LINE_W-1:0] data_pmem_rdata,
    output logic              data_pmem_resp,
    input  logic [BEAT_W-1:0] pmem_rdata,
    input  logic              pmem_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [BEAT_W-1:0] pmem_wdata,
    output logic [ADDR_W-1:0] pmem_addr
`ifdef PMEM_ARB_STATS_EN
    ,
    output logic [31:0]       inst_grant_cnt,
    output logic [31:0]       data_grant_cnt,
    output logic [31:0]       wait_cycles
`endif
);

    localparam int c_BEATS = LINE_W / BEAT_W;
    localparam int c_CNT_W = (c_BEATS > 1) ? $clog2(c_BEATS) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_BEATS - 1);
    localparam int c_OFF_W = 5;

    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_I_RD = 3'd1;
    localparam logic [2:0] c_ST_D_RD = 3'd2;
    localparam logic [2:0] c_ST_D_WR = 3'd3;
    localparam logic [2:0] c_ST_RESP = 3'd4;

    logic [2:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [LINE_W-1:0]  r_buf;
    logic [LINE_W-1:0]  r_wdata;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_last_data;   // 1: most recent grant went to data side
    logic               r_gnt_data;    // side owning the current transaction
    logic               r_pmem_read;
    logic               r_pmem_write;
    logic               r_inst_resp;
    logic               r_data_resp;
    logic [LINE_W-1:0]  r_inst_rdata;
    logic [LINE_W-1:0]  r_data_rdata;

    logic               w_inst_req;
    logic               w_data_req;
    logic               w_any_req;
    logic               w_pick_data;
    logic [LINE_W-1:0]  w_buf_next;

    // The burst always starts at the line base, so the byte offset within
    // the line is intentionally dropped.
    logic w_unused_addr_lsbs;
    assign w_unused_addr_lsbs = ^{inst_pmem_address[c_OFF_W-1:0],
                                  data_pmem_address[c_OFF_W-1:0]};

    assign w_inst_req = inst_pmem_read;
    assign w_data_req = data_pmem_read | data_pmem_write;
    assign w_any_req  = w_inst_req | w_data_req;

    always_comb begin
        // On a tie the side that did not win last time gets the port.
        w_pick_data = w_data_req && (!w_inst_req || !r_last_data);
        // Line buffer with the current beat merged in, so the final beat is
        // already part of the line presented in the response cycle.
        w_buf_next = r_buf;
        w_buf_next[int'(r_cnt)*BEAT_W +: BEAT_W] = pmem_rdata;
    end

    assign pmem_wdata      = r_wdata[int'(r_cnt)*BEAT_W +: BEAT_W];
    assign pmem_read       = r_pmem_read;
    assign pmem_write      = r_pmem_write;
    assign pmem_addr       = r_addr;
    assign inst_pmem_resp  = r_inst_resp;
    assign data_pmem_resp  = r_data_resp;
    assign inst_pmem_rdata = r_inst_rdata;
    assign data_pmem_rdata = r_data_rdata;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= c_ST_IDLE;
            r_cnt        <= '0;
            r_buf        <= '0;
            r_wdata      <= '0;
            r_addr       <= '0;
            r_last_data  <= 1'b0;
            r_gnt_data   <= 1'b0;
            r_pmem_read  <= 1'b0;
            r_pmem_write <= 1'b0;
            r_inst_resp  <= 1'b0;
            r_data_resp  <= 1'b0;
            r_inst_rdata <= '0;
            r_data_rdata <= '0;
        end else begin
            r_inst_resp <= 1'b0;
            r_data_resp <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_any_req) begin
                        r_gnt_data  <= w_pick_data;
                        r_last_data <= w_pick_data;
                        r_cnt       <= '0;
                        if (w_pick_data) begin
                            r_addr  <= {data_pmem_address[ADDR_W-1:c_OFF_W], {c_OFF_W{1'b0}}};
                            r_wdata <= data_pmem_wdata;
                            // A simultaneous read and write is served as a write.
                            if (data_pmem_write) begin
                                r_state      <= c_ST_D_WR;
                                r_pmem_write <= 1'b1;
                            end else begin
                                r_state     <= c_ST_D_RD;
                                r_pmem_read <= 1'b1;
                            end
                        end else begin
                            r_addr      <= {inst_pmem_address[ADDR_W-1:c_OFF_W], {c_OFF_W{1'b0}}};
                            r_state     <= c_ST_I_RD;
                            r_pmem_read <= 1'b1;
                        end
                    end
                end
                c_ST_I_RD, c_ST_D_RD, c_ST_D_WR: begin
                    if (pmem_resp) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_state != c_ST_D_WR) begin
                            r_buf <= w_buf_next;
                        end
                        if (r_cnt == c_LAST) begin
                            r_pmem_read  <= 1'b0;
                            r_pmem_write <= 1'b0;
                            r_state      <= c_ST_RESP;
                            if (r_gnt_data) begin
                                r_data_resp  <= 1'b1;
                                r_data_rdata <= (r_state == c_ST_D_WR) ? r_buf : w_buf_next;
                            end else begin
                                r_inst_resp  <= 1'b1;
                                r_inst_rdata <= w_buf_next;
                            end
                        end
                    end
                end
                c_ST_RESP: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

`ifdef PMEM_ARB_STATS_EN
    logic [31:0] r_inst_grant_cnt;
    logic [31:0] r_data_grant_cnt;
    logic [31:0] r_wait_cycles;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_inst_grant_cnt <= '0;
            r_data_grant_cnt <= '0;
            r_wait_cycles    <= '0;
        end else begin
            if (r_state == c_ST_IDLE && w_any_req) begin
                if (w_pick_data) begin
                    r_data_grant_cnt <= r_data_grant_cnt + 32'd1;
                end else begin
                    r_inst_grant_cnt <= r_inst_grant_cnt + 32'd1;
                end
            end
            // Cycles the losing side spends waiting behind an active transaction.
            if (r_state != c_ST_IDLE && (r_gnt_data ? w_inst_req : w_data_req)) begin
                r_wait_cycles <= r_wait_cycles + 32'd1;
            end
        end
    end

    assign inst_grant_cnt = r_inst_grant_cnt;
    assign data_grant_cnt = r_data_grant_cnt;
    assign wait_cycles    = r_wait_cycles;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pmem_burst_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_pmem_burst_arbiter
// Purpose  : Self-checking bench for pmem_burst_arbiter. Directed scenarios
//            followed by randomized request traffic, compared against a
//            transaction-level reference model (round-robin winner, line
//            assembled from returned beats, beat order of written data).
//            With PMEM_ARB_STATS_EN the statistics outputs are also checked.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pmem_burst_arbiter;

    localparam int LINE_W = 256;
    localparam int BEAT_W = 64;
    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] inst_pmem_address;
    logic              inst_pmem_read;
    logic [LINE_W-1:0] inst_pmem_rdata;
    logic              inst_pmem_resp;
    logic [ADDR_W-1:0] data_pmem_address;
    logic              data_pmem_read;
    logic              data_pmem_write;
    logic [LINE_W-1:0] data_pmem_wdata;
    logic [LINE_W-1:0] data_pmem_rdata;
    logic              data_pmem_resp;
    logic [BEAT_W-1:0] pmem_rdata;
    logic              pmem_resp;
    logic              pmem_read;
    logic              pmem_write;
    logic [BEAT_W-1:0] pmem_wdata;
    logic [ADDR_W-1:0] pmem_addr;
`ifdef PMEM_ARB_STATS_EN
    logic [31:0]       inst_grant_cnt;
    logic [31:0]       data_grant_cnt;
    logic [31:0]       wait_cycles;
`endif

    always #5 clk = ~clk;

    pmem_burst_arbiter #(
        .LINE_W(LINE_W),
        .BEAT_W(BEAT_W),
        .ADDR_W(ADDR_W)
    ) u_dut (
        .clk              (clk),
        .rst              (rst),
        .inst_pmem_address(inst_pmem_address),
        .inst_pmem_read   (inst_pmem_read),
        .inst_pmem_rdata  (inst_pmem_rdata),
        .inst_pmem_resp   (inst_pmem_resp),
        .data_pmem_address(data_pmem_address),
        .data_pmem_read   (data_pmem_read),
        .data_pmem_write  (data_pmem_write),
        .data_pmem_wdata  (data_pmem_wdata),
        .data_pmem_rdata  (data_pmem_rdata),
        .data_pmem_resp   (data_pmem_resp),
        .pmem_rdata       (pmem_rdata),
        .pmem_resp        (pmem_resp),
        .pmem_read        (pmem_read),
        .pmem_write       (pmem_write),
        .pmem_wdata       (pmem_wdata),
        .pmem_addr        (pmem_addr)
`ifdef PMEM_ARB_STATS_EN
        ,
        .inst_grant_cnt   (inst_grant_cnt),
        .data_grant_cnt   (data_grant_cnt),
        .wait_cycles      (wait_cycles)
`endif
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    bit            m_last_data;
    logic [255:0]  m_buf;
    logic [255:0]  m_inst_rdata;
    logic [255:0]  m_data_rdata;
    int            m_inst_grants;
    int            m_data_grants;
    int            m_wait;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    task automatic model_reset();
        m_last_data   = 1'b0;
        m_buf         = '0;
        m_inst_rdata  = '0;
        m_data_rdata  = '0;
        m_inst_grants = 0;
        m_data_grants = 0;
        m_wait        = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pmem_read"},  pmem_read,       1'b0);
        check({tag, "_pmem_write"}, pmem_write,      1'b0);
        check({tag, "_pmem_addr"},  pmem_addr,       '0);
        check({tag, "_pmem_wdata"}, pmem_wdata,      '0);
        check({tag, "_inst_resp"},  inst_pmem_resp,  1'b0);
        check({tag, "_data_resp"},  data_pmem_resp,  1'b0);
        check({tag, "_inst_rdata"}, inst_pmem_rdata, '0);
        check({tag, "_data_rdata"}, data_pmem_rdata, '0);
`ifdef PMEM_ARB_STATS_EN
        check({tag, "_inst_grant_cnt"}, inst_grant_cnt, '0);
        check({tag, "_data_grant_cnt"}, data_grant_cnt, '0);
        check({tag, "_wait_cycles"},    wait_cycles,    '0);
`endif
    endtask

    // Called at a negedge; leaves the bench at a negedge with the DUT idle.
    task automatic do_reset();
        rst             = 1'b0;
        inst_pmem_read  = 1'b0;
        data_pmem_read  = 1'b0;
        data_pmem_write = 1'b0;
        pmem_resp       = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;
        model_reset();
    endtask

    // Serves one transaction from whatever requests are currently driven.
    // Entered at a negedge of an idle cycle; returns at the negedge of the
    // idle cycle following the response.
    task automatic serve(input logic [7:0] gaps, input bit rand_gaps,
                         input bit fixed_beats, input logic [255:0] fixed_line);
        bit           ireq, dreq, g_data, is_wr, other;
        logic [31:0]  a;
        logic [255:0] wd, line;
        logic [63:0]  beat;
        int           gap, cycles;
        ireq = inst_pmem_read;
        dreq = data_pmem_read | data_pmem_write;
        if (ireq && dreq) g_data = !m_last_data;
        else              g_data = dreq;
        m_last_data = g_data;
        if (g_data) m_data_grants++; else m_inst_grants++;
        other  = g_data ? ireq : dreq;
        is_wr  = g_data && data_pmem_write;
        a      = g_data ? data_pmem_address : inst_pmem_address;
        a[4:0] = 5'b0;
        wd     = data_pmem_wdata;
        line   = '0;
        cycles = 0;
        // Memory chatter while idle must be ignored.
        pmem_resp  = 1'($urandom_range(0, 1));
        pmem_rdata = {$urandom, $urandom};
        @(negedge clk);
        check("burst_addr", pmem_addr, a);
        // Granted side's payload may change once captured.
        if (g_data) begin
            data_pmem_address = $urandom;
            data_pmem_wdata   = rand256();
        end else begin
            inst_pmem_address = $urandom;
        end
        for (int k = 0; k < 4; k++) begin
            gap = rand_gaps ? int'($urandom_range(0, 2)) : int'(gaps[2*k +: 2]);
            for (int g = 0; g < gap; g++) begin
                pmem_resp  = 1'b0;
                pmem_rdata = {$urandom, $urandom};
                check("gap_pmem_read",  pmem_read,  !is_wr);
                check("gap_pmem_write", pmem_write, is_wr);
                cycles++;
                @(negedge clk);
            end
            beat = fixed_beats ? fixed_line[64*k +: 64] : {$urandom, $urandom};
            line[64*k +: 64] = beat;
            pmem_resp  = 1'b1;
            pmem_rdata = beat;
            check("beat_pmem_read",  pmem_read,  !is_wr);
            check("beat_pmem_write", pmem_write, is_wr);
            if (is_wr) check("write_beat", pmem_wdata, wd[64*k +: 64]);
            cycles++;
            @(negedge clk);
        end
        pmem_resp  = 1'($urandom_range(0, 1));
        pmem_rdata = {$urandom, $urandom};
        cycles++;
        // Response cycle
        check("resp_pmem_read",  pmem_read,  1'b0);
        check("resp_pmem_write", pmem_write, 1'b0);
        check("resp_inst",       inst_pmem_resp, !g_data);
        check("resp_data",       data_pmem_resp, g_data);
        if (!is_wr) m_buf = line;
        if (g_data) m_data_rdata = m_buf; else m_inst_rdata = m_buf;
        check("resp_inst_rdata", inst_pmem_rdata, m_inst_rdata);
        check("resp_data_rdata", data_pmem_rdata, m_data_rdata);
        if (other) m_wait += cycles;
        if (g_data) begin
            data_pmem_read  = 1'b0;
            data_pmem_write = 1'b0;
        end else begin
            inst_pmem_read = 1'b0;
        end
        @(negedge clk);
        check("idle_inst_resp",  inst_pmem_resp, 1'b0);
        check("idle_data_resp",  data_pmem_resp, 1'b0);
        check("idle_inst_rdata", inst_pmem_rdata, m_inst_rdata);
        check("idle_data_rdata", data_pmem_rdata, m_data_rdata);
        check("idle_pmem_read",  pmem_read,  1'b0);
        check("idle_pmem_write", pmem_write, 1'b0);
    endtask

    initial begin
        logic [255:0] fixed;
        rst               = 1'b0;
        inst_pmem_address = '0;
        inst_pmem_read    = 1'b0;
        data_pmem_address = '0;
        data_pmem_read    = 1'b0;
        data_pmem_write   = 1'b0;
        data_pmem_wdata   = '0;
        pmem_rdata        = '0;
        pmem_resp         = 1'b0;
        model_reset();

        do_reset();

        // Instruction read, consecutive beats with known patterns.
        fixed = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
        inst_pmem_address = 32'h0000_1234;
        inst_pmem_read    = 1'b1;
        serve(8'h00, 1'b0, 1'b1, fixed);
        check("inst_line_value", m_inst_rdata, fixed);

        // Data write, beats accepted on burst cycles 2, 5, 6, 9.
        data_pmem_address = 32'h8000_0040;
        data_pmem_wdata   = rand256();
        data_pmem_write   = 1'b1;
        serve(8'h89, 1'b0, 1'b0, '0);

        // Read and write together: served as a write.
        data_pmem_address = 32'h0000_0040;
        data_pmem_wdata   = rand256();
        data_pmem_read    = 1'b1;
        data_pmem_write   = 1'b1;
        serve(8'h00, 1'b1, 1'b0, '0);

        // Reset after the second beat of an instruction read.
        inst_pmem_address = 32'h0000_2000;
        inst_pmem_read    = 1'b1;
        @(negedge clk);
        check("mid_pmem_read", pmem_read, 1'b1);
        pmem_resp  = 1'b1;
        pmem_rdata = {$urandom, $urandom};
        @(negedge clk);
        pmem_rdata = {$urandom, $urandom};
        @(negedge clk);
        rst            = 1'b0;
        inst_pmem_read = 1'b0;
        pmem_resp      = 1'b0;
        @(negedge clk);
        check("abort_pmem_read", pmem_read, 1'b0);
        check("abort_inst_resp", inst_pmem_resp, 1'b0);
        check("abort_pmem_addr", pmem_addr, '0);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        check("abort_no_resp", inst_pmem_resp, 1'b0);
        inst_pmem_address = 32'h0000_3000;
        inst_pmem_read    = 1'b1;
        serve(8'h00, 1'b0, 1'b0, '0);

        // Simultaneous requests from reset: data, inst, then data again.
        do_reset();
        inst_pmem_address = $urandom;
        inst_pmem_read    = 1'b1;
        data_pmem_address = $urandom;
        data_pmem_read    = 1'b1;
        serve(8'h00, 1'b1, 1'b0, '0);
        check("tie1_inst_still_pending", inst_pmem_read, 1'b1);
        serve(8'h00, 1'b1, 1'b0, '0);
        data_pmem_address = $urandom;
        data_pmem_read    = 1'b1;
        inst_pmem_address = $urandom;
        inst_pmem_read    = 1'b1;
        serve(8'h00, 1'b1, 1'b0, '0);
        check("tie2_data_won", m_last_data, 1'b1);
        serve(8'h00, 1'b1, 1'b0, '0);

        // Randomized traffic.
        for (int it = 0; it < 24; it++) begin
            if (!inst_pmem_read && $urandom_range(0, 1) == 1) begin
                inst_pmem_read    = 1'b1;
                inst_pmem_address = $urandom;
            end
            if (!(data_pmem_read || data_pmem_write) && $urandom_range(0, 1) == 1) begin
                data_pmem_address = $urandom;
                data_pmem_wdata   = rand256();
                case ($urandom_range(0, 2))
                    0:       data_pmem_read = 1'b1;
                    1:       data_pmem_write = 1'b1;
                    default: begin
                        data_pmem_read  = 1'b1;
                        data_pmem_write = 1'b1;
                    end
                endcase
            end
            if (!inst_pmem_read && !data_pmem_read && !data_pmem_write) begin
                inst_pmem_read    = 1'b1;
                inst_pmem_address = $urandom;
            end
            serve(8'h00, 1'b1, 1'b0, '0);
        end
        // Drain whatever is still pending.
        if (inst_pmem_read || data_pmem_read || data_pmem_write) serve(8'h00, 1'b1, 1'b0, '0);
        if (inst_pmem_read || data_pmem_read || data_pmem_write) serve(8'h00, 1'b1, 1'b0, '0);

`ifdef PMEM_ARB_STATS_EN
        @(negedge clk);
        check("stats_inst_grants", inst_grant_cnt, 32'(m_inst_grants));
        check("stats_data_grants", data_grant_cnt, 32'(m_data_grants));
        check("stats_wait_cycles", wait_cycles,    32'(m_wait));
        do_reset();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
